// File: rtl/jtag_dma_engine.sv
// rtl/jtag_dma_engine.sv - JTAG chain-1 DMA engine between the ping-pong buffer and the burst bus
module jtag_dma_engine (
    input  logic        system_clk,
    input  logic        n_reset,
    input  logic        DMA_launch_write,
    input  logic        DMA_launch_read,
    input  logic [31:0] DMA_address,
    input  logic [3:0]  DMA_byte_enable,
    input  logic [7:0]  DMA_burst_size,
    output logic        DMA_busy,
    output logic [7:0]  DMA_block_size,
    output logic        DMA_error,
    output logic [8:0]  pp_address,
    output logic        pp_writeEnable,
    output logic [31:0] pp_dataIn,
    input  logic [31:0] pp_dataOut,
    output logic        bus_request,
    input  logic        bus_grant,
    output logic        bus_begin_transaction,
    output logic        bus_read_n_write,
    output logic [31:0] bus_address_data_out,
    output logic [3:0]  bus_byte_enables,
    output logic [7:0]  bus_burst_size,
    output logic        bus_data_valid_out,
    output logic        bus_end_transaction_out,
    input  logic [31:0] bus_address_data_in,
    input  logic        bus_data_valid_in,
    input  logic        bus_end_transaction_in,
    input  logic        bus_busy_in,
    input  logic        bus_error_in
);
    typedef enum logic [2:0] {
        S_IDLE, S_REQUEST, S_HEADER, S_READ_DATA,
        S_WRITE_PREFETCH, S_WRITE_DATA, S_WRITE_END
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [7:0]  r_size;
    logic        r_is_read;
    logic [8:0]  r_wcnt;
    logic [7:0]  r_block_size;
    logic        r_error;
    logic        r_busy;
    logic        r_request;
    logic        r_begin;
    logic        r_end;
    logic [3:0]  r_bus_be;
    logic [7:0]  r_bus_size;
    logic        r_bus_rnw;

    logic        w_rd_store;
    logic [8:0]  w_rd_cnt;
    logic [7:0]  w_rd_block;
    logic [7:0]  w_err_block;
    logic        w_wr_accept;
    logic        w_last_beat;
    logic [7:0]  w_wr_next;

    // The counter parks at 256 so surplus read beats are acknowledged but never stored.
    assign w_rd_store  = (r_state == S_READ_DATA) && bus_data_valid_in && !r_wcnt[8] && !bus_error_in;
    assign w_rd_cnt    = r_wcnt + {8'd0, w_rd_store};
    assign w_rd_block  = w_rd_cnt[8] ? 8'hFF : w_rd_cnt[7:0];
    assign w_err_block = r_wcnt[8] ? 8'hFF : r_wcnt[7:0];
    assign w_wr_accept = (r_state == S_WRITE_DATA) && !bus_busy_in;
    assign w_last_beat = (r_wcnt[7:0] == r_size);
    assign w_wr_next   = r_wcnt[7:0] + 8'd1;

    always_comb begin
        pp_address = 9'd0;
        case (r_state)
            S_READ_DATA:  pp_address = {1'b0, r_wcnt[7:0]};
            S_WRITE_DATA: pp_address = {1'b0, w_wr_accept ? w_wr_next : r_wcnt[7:0]};
            default:      pp_address = 9'd0;
        endcase
    end

    assign pp_writeEnable          = w_rd_store;
    assign pp_dataIn               = (r_state == S_READ_DATA) ? bus_address_data_in : 32'd0;
    assign bus_data_valid_out      = (r_state == S_WRITE_DATA);
    assign bus_address_data_out    = (r_state == S_HEADER)     ? r_addr :
                                     (r_state == S_WRITE_DATA) ? pp_dataOut : 32'd0;
    assign DMA_busy                = r_busy;
    assign DMA_block_size          = r_block_size;
    assign DMA_error               = r_error;
    assign bus_request             = r_request;
    assign bus_begin_transaction   = r_begin;
    assign bus_end_transaction_out = r_end;
    assign bus_byte_enables        = r_bus_be;
    assign bus_burst_size          = r_bus_size;
    assign bus_read_n_write        = r_bus_rnw;

    always_ff @(posedge system_clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state      <= S_IDLE;
            r_addr       <= 32'd0;
            r_be         <= 4'd0;
            r_size       <= 8'd0;
            r_is_read    <= 1'b0;
            r_wcnt       <= 9'd0;
            r_block_size <= 8'd0;
            r_error      <= 1'b0;
            r_busy       <= 1'b0;
            r_request    <= 1'b0;
            r_begin      <= 1'b0;
            r_end        <= 1'b0;
            r_bus_be     <= 4'd0;
            r_bus_size   <= 8'd0;
            r_bus_rnw    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (DMA_launch_write || DMA_launch_read) begin
                        r_addr    <= DMA_address;
                        r_be      <= DMA_byte_enable;
                        r_size    <= DMA_burst_size;
                        r_is_read <= !DMA_launch_write;
                        r_error   <= 1'b0;
                        r_wcnt    <= 9'd0;
                        r_busy    <= 1'b1;
                        r_request <= 1'b1;
                        r_state   <= S_REQUEST;
                    end
                end
                S_REQUEST: begin
                    if (bus_grant) begin
                        r_bus_be   <= r_be;
                        r_bus_size <= r_size;
                        r_bus_rnw  <= r_is_read;
                        r_begin    <= 1'b1;
                        r_state    <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    r_begin <= 1'b0;
                    if (bus_error_in) begin
                        r_error   <= 1'b1;
                        if (r_is_read)
                            r_block_size <= w_err_block;
                        r_busy    <= 1'b0;
                        r_request <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_state <= r_is_read ? S_READ_DATA : S_WRITE_PREFETCH;
                    end
                end
                S_READ_DATA: begin
                    if (bus_error_in) begin
                        r_error      <= 1'b1;
                        r_block_size <= w_err_block;
                        r_busy       <= 1'b0;
                        r_request    <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_wcnt <= w_rd_cnt;
                        if (bus_end_transaction_in) begin
                            r_block_size <= w_rd_block;
                            r_busy       <= 1'b0;
                            r_request    <= 1'b0;
                            r_state      <= S_IDLE;
                        end
                    end
                end
                S_WRITE_PREFETCH: begin
                    if (bus_error_in) begin
                        r_error   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_request <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_state <= S_WRITE_DATA;
                    end
                end
                S_WRITE_DATA: begin
                    if (bus_error_in) begin
                        r_error   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_request <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (w_wr_accept) begin
                        r_wcnt <= r_wcnt + 9'd1;
                        if (w_last_beat) begin
                            r_end   <= 1'b1;
                            r_state <= S_WRITE_END;
                        end
                    end
                end
                S_WRITE_END: begin
                    r_end     <= 1'b0;
                    r_busy    <= 1'b0;
                    r_request <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_begin   <= 1'b0;
                    r_end     <= 1'b0;
                    r_busy    <= 1'b0;
                    r_request <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end
endmodule
